// File: rtl/count_run_pkg.sv
// Shared types and helpers for the count-run arbiter slice.
package count_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 2;

  // Ceiling log2, never less than 1 so index buses always have a bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from NREQ-1 back to 0. Returns a one-hot grant and its index.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx
);

  // Scan the requesters starting at the pointer and keep the first hit.
  always_comb begin
    logic found_s;
    int   cand_s;
    gnt     = {NREQ{1'b0}};
    idx     = {IDXW{1'b0}};
    found_s = 1'b0;
    cand_s  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = (int'(ptr) + i) % NREQ;
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = IDXW'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/count_run_arbiter.sv
// Count-run arbiter: grants one requester at a time the shared run counter,
// counts 0..limit for it and pulses done on completion.
// Build option: define COUNT_RUN_ARB_PRIO_EN for fixed priority (requester 0
// highest) instead of round-robin.
module count_run_arbiter
  import count_run_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IDXW  = clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] limit,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      Q,
  output logic                  upper,
  output logic [NREQ-1:0]       done,
  output logic [IDXW-1:0]       owner
);

  localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  state_t            state_r, state_n;
  logic [WIDTH-1:0]  q_r, q_n;
  logic [WIDTH-1:0]  lim_r, lim_n;
  logic [NREQ-1:0]   grant_r, grant_n;
  logic [NREQ-1:0]   done_r, done_n;
  logic              busy_r, busy_n;
  logic [IDXW-1:0]   owner_r, owner_n;

  logic [IDXW-1:0]   ptr_s;
  logic              ptr_adv_s;
  logic [IDXW-1:0]   ptr_nxt_s;
  logic [NREQ-1:0]   pick_gnt_s;
  logic [IDXW-1:0]   pick_idx_s;
  logic [WIDTH-1:0]  lim_arr_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_lim
    assign lim_arr_s[g] = limit[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req (req),
    .ptr (ptr_s),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  // Slot after the current owner, wrapping; this is where the next search starts.
  assign ptr_nxt_s = (owner_r == LAST_IDX) ? {IDXW{1'b0}} : (owner_r + ONE_IDX);

`ifdef COUNT_RUN_ARB_PRIO_EN
  // Fixed priority: search always starts at requester 0.
  assign ptr_s = {IDXW{1'b0}};
`else
  logic [IDXW-1:0] ptr_r;

  // Round-robin pointer moves past the owner when its run ends or aborts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r <= {IDXW{1'b0}};
    end else if (ptr_adv_s) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`endif

  // Next-state and next-output logic for IDLE/RUN/DONE sequencing.
  always_comb begin
    state_n   = state_r;
    q_n       = q_r;
    lim_n     = lim_r;
    grant_n   = grant_r;
    done_n    = {NREQ{1'b0}};
    owner_n   = owner_r;
    ptr_adv_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_n = RUN;
          grant_n = pick_gnt_s;
          owner_n = pick_idx_s;
          lim_n   = lim_arr_s[pick_idx_s];
          q_n     = {WIDTH{1'b0}};
        end else begin
          state_n = IDLE;
          grant_n = {NREQ{1'b0}};
        end
      end
      RUN: begin
        // Abort wins over terminal count on the same edge.
        if (!req[owner_r]) begin
          state_n   = IDLE;
          grant_n   = {NREQ{1'b0}};
          q_n       = {WIDTH{1'b0}};
          ptr_adv_s = 1'b1;
        end else if (q_r == lim_r) begin
          state_n          = DONE;
          grant_n          = {NREQ{1'b0}};
          done_n[owner_r]  = 1'b1;
          ptr_adv_s        = 1'b1;
        end else begin
          q_n = q_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_n = IDLE;
        q_n     = {WIDTH{1'b0}};
        grant_n = {NREQ{1'b0}};
      end
      default: begin
        state_n = IDLE;
        q_n     = {WIDTH{1'b0}};
        grant_n = {NREQ{1'b0}};
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      q_r     <= {WIDTH{1'b0}};
      lim_r   <= {WIDTH{1'b0}};
      grant_r <= {NREQ{1'b0}};
      done_r  <= {NREQ{1'b0}};
      busy_r  <= 1'b0;
      owner_r <= {IDXW{1'b0}};
    end else begin
      state_r <= state_n;
      q_r     <= q_n;
      lim_r   <= lim_n;
      grant_r <= grant_n;
      done_r  <= done_n;
      busy_r  <= busy_n;
      owner_r <= owner_n;
    end
  end

  assign grant = grant_r;
  assign busy  = busy_r;
  assign Q     = q_r;
  assign done  = done_r;
  assign owner = owner_r;
  assign upper = (state_r == RUN) && (q_r == lim_r);

endmodule

// File: tb/tb_count_run_arbiter.sv
// Directed self-checking bench for count_run_arbiter (NREQ=2, WIDTH=4).
module tb_count_run_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req;
  logic [7:0]  limit;
  logic [1:0]  grant;
  logic        busy;
  logic [3:0]  Q;
  logic        upper;
  logic [1:0]  done;
  logic [0:0]  owner;

  int checks;
  int errors;

  count_run_arbiter #(.NREQ(2), .WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .limit (limit),
    .grant (grant),
    .busy  (busy),
    .Q     (Q),
    .upper (upper),
    .done  (done),
    .owner (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for a grant (bounded), then follows a full run of length lim.
  task automatic do_run(input int exp_owner, input int lim);
    int waited;
    waited = 0;
    do begin
      tick();
      waited = waited + 1;
    end while (grant == 2'b00 && waited < 8);
    chk("grant", grant, 32'(1 << exp_owner));
    chk("owner", owner, exp_owner);
    chk("busy_run", busy, 1);
    chk("q_start", Q, 0);
    chk("upper_start", upper, (lim == 0) ? 1 : 0);
    for (int k = 1; k <= lim; k++) begin
      tick();
      chk("q_step", Q, k);
      chk("upper_step", upper, (k == lim) ? 1 : 0);
      chk("grant_hold", grant, 32'(1 << exp_owner));
    end
    tick();
    chk("done_pulse", done, 32'(1 << exp_owner));
    chk("grant_done", grant, 0);
    chk("busy_done", busy, 1);
    chk("q_hold", Q, lim);
    chk("upper_done", upper, 0);
    tick();
    chk("done_clear", done, 0);
    chk("q_idle", Q, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int exp_own;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req    = 2'b00;
    limit  = 8'h00;

    // 1: reset held, then idle with no requests
    repeat (3) tick();
    chk("rst_grant", grant, 0);
    chk("rst_q", Q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_upper", upper, 0);
    chk("rst_done", done, 0);
    chk("rst_owner", owner, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_grant", grant, 0);
      chk("idle_q", Q, 0);
      chk("idle_busy", busy, 0);
      chk("idle_upper", upper, 0);
    end

    // 2: single run for requester 0 up to 5
    limit = {4'd0, 4'd5};
    req   = 2'b01;
    do_run(0, 5);
    req = 2'b00;

    // 3: both requesting; owners must alternate (RR) or stay 0 (priority)
    limit = {4'd3, 4'd2};
    req   = 2'b11;
`ifdef COUNT_RUN_ARB_PRIO_EN
    exp_own = 0;
`else
    exp_own = 1;
`endif
    for (int r = 0; r < 3; r++) begin
      do_run(exp_own, (exp_own == 1) ? 3 : 2);
`ifndef COUNT_RUN_ARB_PRIO_EN
      exp_own = 1 - exp_own;
`endif
    end
    req = 2'b00;

    // 4: zero limit on requester 1, one-cycle run
    limit = {4'd0, 4'd2};
    req   = 2'b10;
    do_run(1, 0);
    req = 2'b00;

    // 5: abort requester 0 at Q=7; limit change mid-run is ignored
    limit = {4'd15, 4'd15};
    req   = 2'b01;
    tick();
    chk("ab_grant", grant, 2'b01);
    limit = {4'd15, 4'd3};
    for (int k = 1; k <= 7; k++) tick();
    chk("ab_q7", Q, 7);
    chk("ab_upper7", upper, 0);
    req = 2'b10;
    tick();
    chk("ab_grant_drop", grant, 0);
    chk("ab_q_clear", Q, 0);
    chk("ab_no_done", done, 0);
    chk("ab_busy", busy, 0);
    tick();
    chk("ab_next_grant", grant, 2'b10);
    chk("ab_next_owner", owner, 1);
    chk("ab_done_still0", done, 0);

    // 6: asynchronous reset in mid-run at Q=9
    for (int k = 1; k <= 9; k++) tick();
    chk("ar_q9", Q, 9);
    chk("ar_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_q", Q, 0);
    chk("ar_busy0", busy, 0);
    chk("ar_upper", upper, 0);
    chk("ar_done", done, 0);
    req = 2'b00;
    tick();
    reset = 1'b1;

    // full-range run: limit 15 reaches all-ones without wrapping
    limit = {4'd0, 4'd15};
    req   = 2'b01;
    do_run(0, 15);
    req = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
